clock_ctrl: RTL and testbench
=============================

CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 Parameter DIV_WIDTH, default 8, width of the half-period divider setting.
REQ-002 Parameter DEB_CYCLES, default 16, number of consecutive stable samples needed to accept a manual-button level change.
REQ-003 Parameter STEP_WIDTH, default 8, width of the burst step counter.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 select  input  1  1 = free-run (astable) mode, 0 = manual mode.
REQ-007 mpulse  input  1  raw, asynchronous, bouncy manual push-button.
REQ-008 hlt  input  1  halt request from the CPU control word, level-sensitive.
REQ-009 resume  input  1  single-cycle pulse that releases a latched halt.
REQ-010 div  input  DIV_WIDTH  half-period of the free-run clock, minus one, in clk cycles.
REQ-011 burst_cnt  input  STEP_WIDTH  number of cpu_clk periods to issue on burst_go.
REQ-012 burst_go  input  1  single-cycle pulse that starts a burst in manual mode.
REQ-013 cpu_clk  output  1  registered computer clock.
REQ-014 cpu_clk_rise  output  1  one-cycle pulse, asserted in the clk cycle after cpu_clk goes 0->1.
REQ-015 halted  output  1  high while in HALT.
REQ-016 mode  output  2  current state: 00 MANUAL, 01 RUN, 10 BURST, 11 HALT.
REQ-017 steps_left  output  STEP_WIDTH  remaining burst periods.

Function
REQ-018 The block SHALL be a four-state machine: MANUAL, RUN, BURST, HALT.
REQ-019 Transition priority SHALL be: hlt, then select, then burst_go.
REQ-020 A divider counter SHALL run only in RUN and BURST.
- It counts 0..div, toggles cpu_clk on the cycle it equals div, then returns to 0.
- cpu_clk period is 2*(div+1) clk cycles; div=0 gives clk/2.
REQ-021 div SHALL be sampled at each counter wrap only; a change mid-half-period SHALL NOT shorten the current half-period.
REQ-022 Outside RUN and BURST the divider counter SHALL be held at 0.
REQ-023 mpulse SHALL pass through a 2-flop synchroniser and then a debouncer.
- The debounced level changes only after DEB_CYCLES consecutive equal synchronised samples.
- Any differing sample restarts the stability count.
REQ-024 In MANUAL, cpu_clk SHALL follow the debounced mpulse level, registered.
REQ-025 MANUAL->RUN when select=1; the divider restarts at 0 with cpu_clk low.
- If cpu_clk was high, it SHALL first drop low on that transition.
REQ-026 RUN->MANUAL when select=0, taken only at a divider wrap that drives cpu_clk low, so no runt high pulse occurs.
REQ-027 MANUAL->BURST on burst_go with burst_cnt!=0, select=0, hlt=0.
- steps_left loads burst_cnt; cpu_clk starts low.
- burst_go with burst_cnt=0 SHALL be ignored.
REQ-028 In BURST, steps_left SHALL decrement at each cpu_clk high->low toggle.
- BURST->MANUAL when the toggle takes steps_left to 0, with cpu_clk low.
- Exactly burst_cnt full periods are emitted.
REQ-029 In BURST, select=1 SHALL be ignored until the burst ends; select is then evaluated from MANUAL.
REQ-030 From any state, hlt=1 SHALL enter HALT on the next clk edge.
- cpu_clk is forced to 0 in that same edge, matching the combinational halt-overrides-all behaviour of the single-bit clock.
- steps_left clears to 0.
REQ-031 HALT SHALL be sticky.
- Exit only on resume=1 while hlt=0, to MANUAL; select is then evaluated normally.
- resume while hlt=1 SHALL be ignored.
REQ-032 burst_go and mpulse changes while in HALT SHALL have no effect on cpu_clk.
REQ-033 cpu_clk_rise SHALL never assert twice within one cpu_clk period.

Reset
REQ-034 While rst_n=0, all of the following SHALL hold immediately, independent of clk:
- mode=MANUAL, cpu_clk=0, cpu_clk_rise=0, halted=0, steps_left=0.
- Divider, debounce counter, synchroniser flops and debounced level are all 0.
REQ-035 After rst_n deasserts, the first state transition SHALL occur no earlier than the first clk edge.
- With select=1, RUN is entered on that edge.
REQ-036 Reset asserted mid-burst or mid-halt SHALL abandon the operation with no further cpu_clk edges.

Verification
REQ-037 Free-run: select=1, div=3 -> cpu_clk high 4 / low 4 clk cycles; one cpu_clk_rise per 8 cycles.
REQ-038 Debounce: DEB_CYCLES=16, mpulse bouncing 5 times within 10 cycles then steady high -> exactly one cpu_clk rise, 16 cycles after the last bounce plus synchroniser delay.
REQ-039 Burst: select=0, div=1, burst_cnt=3, burst_go -> exactly 3 cpu_clk periods of 4 cycles each; steps_left 3->2->1->0; mode returns to 00 with cpu_clk=0.
REQ-040 Halt: hlt=1 while cpu_clk high in RUN -> cpu_clk=0 next edge, mode=11. resume with hlt=1 -> stays halted. hlt=0 then resume -> MANUAL, then RUN.
REQ-041 Mode switch: select 1->0 while cpu_clk high, div=5 -> cpu_clk completes its 6-cycle high phase, then mode=00; no high pulse shorter than 6 cycles.
REQ-042 Reset mid-burst: rst_n=0 with steps_left=2 -> cpu_clk=0 and steps_left=0 asynchronously; no cpu_clk activity until select or burst_go after release.

Source files
------------

// File: rtl/clock_ctrl.sv
// Computer clock controller: manual (debounced button), free-run, counted burst and sticky halt.
// cpu_clk is always a registered output; every mode change lands on a clean low phase.
module clock_ctrl #(
  parameter int unsigned DIV_WIDTH  = 8,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned STEP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  select,
  input  logic                  mpulse,
  input  logic                  hlt,
  input  logic                  resume,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [STEP_WIDTH-1:0] burst_cnt,
  input  logic                  burst_go,
  output logic                  cpu_clk,
  output logic                  cpu_clk_rise,
  output logic                  halted,
  output logic [1:0]            mode,
  output logic [STEP_WIDTH-1:0] steps_left
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_RUN    = 2'b01,
    ST_BURST  = 2'b10,
    ST_HALT   = 2'b11
  } state_t;

  state_t                state, state_nxt;
  logic                  clk_nxt;
  logic [DIV_WIDTH-1:0]  div_cnt, cnt_nxt;
  logic [DIV_WIDTH-1:0]  div_lat, div_lat_nxt;
  logic [STEP_WIDTH-1:0] steps_nxt;
  logic [1:0]            sync_q;
  logic [DEB_W-1:0]      deb_cnt;
  logic                  deb_level;
  logic                  wrap;

  // Button path: two-flop synchroniser, then level accepted only after a stable run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      deb_cnt   <= '0;
      deb_level <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], mpulse};
      if (sync_q[1] == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        deb_level <= sync_q[1];
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Half-period length comes from div_lat, refreshed only at wraps and mode entry.
  assign wrap = (div_cnt == div_lat);

  always_comb begin
    state_nxt   = state;
    clk_nxt     = cpu_clk;
    cnt_nxt     = div_cnt;
    div_lat_nxt = div_lat;
    steps_nxt   = steps_left;
    if (hlt) begin
      state_nxt = ST_HALT;
      clk_nxt   = 1'b0;
      cnt_nxt   = '0;
      steps_nxt = '0;
    end else begin
      case (state)
        ST_MANUAL: begin
          cnt_nxt = '0;
          clk_nxt = deb_level;
          if (select) begin
            state_nxt   = ST_RUN;
            clk_nxt     = 1'b0;
            div_lat_nxt = div;
          end else if (burst_go && (burst_cnt != '0)) begin
            state_nxt   = ST_BURST;
            clk_nxt     = 1'b0;
            div_lat_nxt = div;
            steps_nxt   = burst_cnt;
          end
        end
        ST_RUN: begin
          if (wrap) begin
            cnt_nxt     = '0;
            div_lat_nxt = div;
            clk_nxt     = ~cpu_clk;
            if (!select && cpu_clk) state_nxt = ST_MANUAL;
          end else begin
            cnt_nxt = div_cnt + 1'b1;
          end
        end
        ST_BURST: begin
          if (wrap) begin
            cnt_nxt     = '0;
            div_lat_nxt = div;
            clk_nxt     = ~cpu_clk;
            if (cpu_clk) begin
              steps_nxt = steps_left - 1'b1;
              if (steps_left == STEP_WIDTH'(1)) state_nxt = ST_MANUAL;
            end
          end else begin
            cnt_nxt = div_cnt + 1'b1;
          end
        end
        ST_HALT: begin
          cnt_nxt = '0;
          clk_nxt = 1'b0;
          if (resume) state_nxt = ST_MANUAL;
        end
        default: begin
          state_nxt = ST_MANUAL;
          clk_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_MANUAL;
      cpu_clk      <= 1'b0;
      cpu_clk_rise <= 1'b0;
      div_cnt      <= '0;
      div_lat      <= '0;
      steps_left   <= '0;
    end else begin
      state        <= state_nxt;
      cpu_clk      <= clk_nxt;
      cpu_clk_rise <= clk_nxt & ~cpu_clk;
      div_cnt      <= cnt_nxt;
      div_lat      <= div_lat_nxt;
      steps_left   <= steps_nxt;
    end
  end

  assign halted = (state == ST_HALT);
  assign mode   = state;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: randomized divider/burst settings checked against
// phase lengths, period counts and latencies computed from the clocking rules.
module tb_clock_ctrl;
  localparam int unsigned DIV_WIDTH  = 8;
  localparam int unsigned DEB_CYCLES = 16;
  localparam int unsigned STEP_WIDTH = 8;

  logic clk = 1'b0, rst_n = 1'b0, select = 1'b0, mpulse = 1'b0;
  logic hlt = 1'b0, resume = 1'b0, burst_go = 1'b0;
  logic [DIV_WIDTH-1:0]  div = '0;
  logic [STEP_WIDTH-1:0] burst_cnt = '0;
  logic cpu_clk, cpu_clk_rise, halted;
  logic [1:0] mode;
  logic [STEP_WIDTH-1:0] steps_left;

  int n_chk = 0, n_pass = 0;
  logic prev_clk = 1'b0;
  bit prev_ok = 1'b0;

  clock_ctrl #(.DIV_WIDTH(DIV_WIDTH), .DEB_CYCLES(DEB_CYCLES), .STEP_WIDTH(STEP_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .select(select), .mpulse(mpulse), .hlt(hlt), .resume(resume),
    .div(div), .burst_cnt(burst_cnt), .burst_go(burst_go), .cpu_clk(cpu_clk),
    .cpu_clk_rise(cpu_clk_rise), .halted(halted), .mode(mode), .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Rise pulse must mark exactly the first high sample of every cpu_clk period.
  always @(negedge clk) begin
    if (rst_n && prev_ok) chk("rise_pulse", cpu_clk_rise, cpu_clk & ~prev_clk);
    prev_clk = cpu_clk;
    prev_ok  = rst_n;
  end

  task automatic wait_clk(input logic v, input int budget);
    int k = 0;
    while (cpu_clk !== v && k < budget) begin tick(); k++; end
    chk("wait_cpu_clk", cpu_clk, v);
  endtask

  task automatic wait_mode(input logic [1:0] m, input int budget);
    int k = 0;
    while (mode !== m && k < budget) begin tick(); k++; end
    chk("wait_mode", mode, m);
  endtask

  // Ends on the first high sample of the period following the measured one.
  task automatic measure(output int hi, output int lo);
    hi = 0; lo = 0;
    wait_clk(1'b0, 600);
    wait_clk(1'b1, 600);
    while (cpu_clk === 1'b1 && hi < 600) begin hi++; tick(); end
    while (cpu_clk === 1'b0 && lo < 600) begin lo++; tick(); end
  endtask

  task automatic run_burst(input int d, input int n, input bit sel_mid);
    int cyc = 0, rises = 0, decs = 0;
    logic [STEP_WIDTH-1:0] prev;
    div = DIV_WIDTH'(d); burst_cnt = STEP_WIDTH'(n);
    burst_go = 1'b1; tick(); burst_go = 1'b0;
    chk("burst_entry_mode", mode, 2);
    chk("burst_load", steps_left, n);
    chk("burst_start_low", cpu_clk, 0);
    prev = steps_left;
    while (mode === 2'b10 && cyc < 2000) begin
      if (cpu_clk_rise) rises++;
      if (steps_left !== prev) begin
        chk("burst_dec", steps_left, prev - 1);
        decs++;
        prev = steps_left;
      end
      cyc++;
      if (sel_mid && cyc == 2) select = 1'b1;
      tick();
    end
    chk("burst_cycles", cyc, n * 2 * (d + 1));
    chk("burst_periods", rises, n);
    chk("burst_decs", decs, n - 1);
    chk("burst_end_steps", steps_left, 0);
    chk("burst_end_mode", mode, 0);
    chk("burst_end_low", cpu_clk, 0);
    if (sel_mid) begin
      tick();
      chk("select_after_burst", mode, 1);
      select = 1'b0;
      wait_mode(2'b00, 100);
    end
  endtask

  initial begin
    int hi, lo, d, cnt;
    #500_000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1);
  end

  initial begin
    int hi, lo, d, cnt, lat;
    #1;
    chk("rst_mode", mode, 0);
    chk("rst_cpu_clk", cpu_clk, 0);
    chk("rst_rise", cpu_clk_rise, 0);
    chk("rst_halted", halted, 0);
    chk("rst_steps", steps_left, 0);

    // Free-run from reset release, several dividers.
    select = 1'b1; div = 8'd3;
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("run_entry_mode", mode, 1);
    chk("run_entry_low", cpu_clk, 0);
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 3 : (i == 1) ? 0 : int'($urandom_range(1, 9));
      div = DIV_WIDTH'(d);
      measure(hi, lo);
      measure(hi, lo);
      chk("run_high_len", hi, d + 1);
      chk("run_low_len", lo, d + 1);
      cnt = 0;
      for (int k = 0; k < 8 * (d + 1); k++) begin
        if (cpu_clk_rise) cnt++;
        tick();
      end
      chk("run_rises_4p", cnt, 4);
    end

    // A divider change mid half-period takes effect only at the next wrap.
    div = 8'd5;
    measure(hi, lo);
    measure(hi, lo);
    hi = 0;
    repeat (2) begin if (cpu_clk === 1'b1) hi++; tick(); end
    div = 8'd0;
    while (cpu_clk === 1'b1 && hi < 100) begin hi++; tick(); end
    chk("div_mid_high", hi, 6);
    lo = 0;
    while (cpu_clk === 1'b0 && lo < 100) begin lo++; tick(); end
    chk("div_new_low", lo, 1);

    // Leaving RUN while high finishes the full high phase.
    div = 8'd5;
    measure(hi, lo);
    measure(hi, lo);
    hi = 0;
    repeat (2) begin if (cpu_clk === 1'b1) hi++; tick(); end
    select = 1'b0;
    while (cpu_clk === 1'b1 && hi < 100) begin hi++; tick(); end
    chk("switch_high_len", hi, 6);
    chk("switch_mode", mode, 0);
    cnt = 0;
    repeat (30) begin if (cpu_clk === 1'b1) cnt++; tick(); end
    chk("manual_idle_high", cnt, 0);

    // Bouncy button: 5 toggles inside 10 cycles, ending high.
    for (int i = 0; i < 5; i++) begin
      mpulse = ~mpulse;
      if (i < 4) tick(int'($urandom_range(1, 2)));
    end
    lat = 0;
    do begin tick(); lat++; end while (cpu_clk !== 1'b1 && lat < 100);
    chk("deb_latency", lat, DEB_CYCLES + 3);
    cnt = 0;
    repeat (40) begin if (cpu_clk_rise) cnt++; tick(); end
    chk("deb_one_rise", cnt, 0 + 1);
    chk("deb_level_high", cpu_clk, 1);
    mpulse = 1'b0;
    tick(DEB_CYCLES + 5);
    chk("deb_release_low", cpu_clk, 0);

    // Bursts: directed, then random, then with select raised mid-burst.
    run_burst(1, 3, 1'b0);
    for (int i = 0; i < 3; i++)
      run_burst(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 1'b0);
    run_burst(int'($urandom_range(0, 2)), int'($urandom_range(2, 4)), 1'b1);
    burst_cnt = '0; burst_go = 1'b1; tick(); burst_go = 1'b0;
    chk("burst_zero_mode", mode, 0);
    tick(5);
    chk("burst_zero_idle", cpu_clk, 0);

    // Halt from RUN while cpu_clk is high.
    select = 1'b1; div = 8'd3;
    wait_mode(2'b01, 10);
    wait_clk(1'b1, 100);
    hlt = 1'b1; tick();
    chk("halt_clk_low", cpu_clk, 0);
    chk("halt_mode", mode, 3);
    chk("halt_flag", halted, 1);
    chk("halt_steps", steps_left, 0);
    resume = 1'b1; tick(); resume = 1'b0;
    chk("halt_resume_ignored", mode, 3);
    mpulse = 1'b1; burst_go = 1'b1; burst_cnt = 8'd2; tick(); burst_go = 1'b0;
    cnt = 0;
    repeat (30) begin if (cpu_clk === 1'b1) cnt++; tick(); end
    chk("halt_no_clk", cnt, 0);
    hlt = 1'b0; tick(2);
    chk("halt_sticky", mode, 3);
    resume = 1'b1; tick(); resume = 1'b0;
    chk("resume_manual", mode, 0);
    chk("resume_unhalted", halted, 0);
    tick();
    chk("resume_then_run", mode, 1);
    mpulse = 1'b0; select = 1'b0;
    wait_mode(2'b00, 100);
    tick(DEB_CYCLES + 5);

    // Halt in the middle of a burst clears the remaining count.
    div = 8'd1; burst_cnt = 8'd4; burst_go = 1'b1; tick(); burst_go = 1'b0;
    tick(3);
    hlt = 1'b1; tick();
    chk("burst_halt_steps", steps_left, 0);
    chk("burst_halt_mode", mode, 3);
    chk("burst_halt_low", cpu_clk, 0);
    hlt = 1'b0; resume = 1'b1; tick(); resume = 1'b0;
    chk("burst_halt_exit", mode, 0);

    // Asynchronous reset mid-burst.
    div = 8'd1; burst_cnt = 8'd4; burst_go = 1'b1; tick(); burst_go = 1'b0;
    cnt = 0;
    while (steps_left !== 8'd2 && cnt < 100) begin tick(); cnt++; end
    chk("rst_burst_reach2", steps_left, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cpu_clk", cpu_clk, 0);
    chk("arst_steps", steps_left, 0);
    chk("arst_mode", mode, 0);
    chk("arst_rise", cpu_clk_rise, 0);
    tick(3);
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin if (cpu_clk === 1'b1 || mode !== 2'b00) cnt++; tick(); end
    chk("post_rst_quiet", cnt, 0);
    select = 1'b1; tick();
    chk("post_rst_run", mode, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
